// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    STOP,
    ACK,
    WAITIDLE
  } ps2_tx_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 pins plus a falling-edge detector on the clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_d;

  // Flops reset to 1, the idle level of the bus, so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_d     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous stage's old value,
      // which is what builds a real shift chain instead of collapsing it into one flop.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_d     <= clk_sync[1];
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  assign fall   = clk_d & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift-out on device clock, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int CNT_MAX = max_int(INHIBIT_CYCLES, TIMEOUT_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Fall count just before the one that drives parity (the last shifted bit).
  localparam logic [3:0] PARITY_FALL = 4'(FRAME_BITS - 3);

  ps2_tx_state_t    state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       shift_reg;
  logic             ps2_clk_s;
  logic             ps2_data_s;
  logic             ps2_fall;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_s    (ps2_clk_s),
    .data_s   (ps2_data_s),
    .fall     (ps2_fall)
  );

  // NOTE: all outputs are registers, so the open-drain enables never glitch and the
  // asynchronous reset releases both lines in the same instant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            shift_reg  <= {1'b1, ~^tx_data, tx_data};
            ack_err    <= 1'b0;
            timeout    <= 1'b0;
            tx_ready   <= 1'b0;
            ps2_clk_oe <= 1'b1;
            cnt        <= '0;
            bit_cnt    <= '0;
            state      <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            cnt         <= '0;
            state       <= REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        REQ, STOP, ACK, WAITIDLE: begin
          // A device edge takes priority over an expiring timeout on the same cycle.
          if (ps2_fall) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            case (state)
              REQ: begin
                ps2_data_oe <= ~shift_reg[0];
                shift_reg   <= shift_reg >> 1;
                if (bit_cnt == PARITY_FALL) state <= STOP;
              end
              STOP: begin
                ps2_data_oe <= 1'b0;
                state       <= ACK;
              end
              ACK: begin
                ack_err <= ps2_data_s;
                state   <= WAITIDLE;
              end
              default: ;
            endcase
          end else if (state == WAITIDLE && ps2_clk_s && ps2_data_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            timeout     <= 1'b1;
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural open-drain keyboard model and scoreboards.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  typedef struct packed {
    logic ack_err;
    logic timeout;
  } status_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       done;
  logic       ack_err;
  logic       timeout;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout)
  );

  int n_vec       = 0;
  int n_miscmp    = 0;
  int done_cnt    = 0;
  int n_done_exp  = 0;
  int frames_seen = 0;

  logic [9:0] exp_frame_q[$];
  status_t    exp_status_q[$];

  bit kb_silent      = 1'b0;
  bit kb_ack         = 1'b1;
  int kb_abort_after = 0;
  bit mid_evt        = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame as the device sees it: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  always @(negedge clk) if (resetn && done) done_cnt++;

  // Keyboard model: clocks the frame in after a request, samples on rising edges, then ACKs.
  initial begin
    logic [9:0] frame;
    bit         aborted;
    forever begin
      @(negedge ps2_clk_oe);
      if (ps2_data_oe && !kb_silent) begin
        repeat (20) @(posedge clk);
        frame   = '0;
        aborted = 1'b0;
        for (int i = 0; i < 10; i++) begin
          dev_clk_low = 1'b1;
          repeat (HALF) @(posedge clk);
          dev_clk_low = 1'b0;
          frame[i] = ps2_data;
          if (i + 1 == kb_abort_after) begin
            aborted = 1'b1;
            mid_evt = 1'b1;
            break;
          end
          repeat (HALF) @(posedge clk);
        end
        if (!aborted) begin
          dev_data_low = kb_ack;
          repeat (2) @(posedge clk);
          dev_clk_low = 1'b1;
          repeat (HALF) @(posedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF) @(posedge clk);
          dev_data_low = 1'b0;
          frames_seen++;
          check("frame_q_nonempty", 32'(exp_frame_q.size() != 0), 1);
          if (exp_frame_q.size() != 0) check("frame", frame, exp_frame_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic exp_ack, input logic exp_to,
                      input bit frame_exp, input bit done_exp);
    int      n = 0;
    status_t st;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (frame_exp) exp_frame_q.push_back(exp_frame(d));
    if (done_exp) begin
      st.ack_err = exp_ack;
      st.timeout = exp_to;
      exp_status_q.push_back(st);
      n_done_exp++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check("accept_ready_low", tx_ready, 0);
    check("accept_clk_oe", ps2_clk_oe, 1);
  endtask

  task automatic wait_done(input string tag);
    int      n = 0;
    status_t e = '0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    if (exp_status_q.size() != 0) e = exp_status_q.pop_front();
    check({tag, "_ack_err"}, ack_err, e.ack_err);
    check({tag, "_timeout"}, timeout, e.timeout);
    @(negedge clk);
    check({tag, "_ready_after"}, tx_ready, 1);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int saved_done;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_timeout", timeout, 0);
    resetn = 1'b1;
    @(negedge clk);

    send(8'hED, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("send_ed");
    send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("send_00");
    send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("send_ff");
    send(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("send_01");

    kb_ack = 1'b0;
    send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done("nack");
    kb_ack = 1'b1;

    // Silent device: measure inhibit length and the timeout from REQ entry.
    kb_silent = 1'b1;
    send(8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
    n = 1;
    while (ps2_clk_oe && n < 1000) begin
      @(negedge clk);
      if (ps2_clk_oe) n++;
    end
    check("inhibit_cycles", n, INH);
    check("req_start_bit", ps2_data_oe, 1);
    n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TO);
    check("timeout_clk_oe", ps2_clk_oe, 0);
    check("timeout_data_oe", ps2_data_oe, 0);
    wait_done("timeout");
    kb_silent = 1'b0;

    // Reset after the 4th data bit; 0x92 has bit 3 low so data is being driven.
    kb_abort_after = 4;
    send(8'h92, 1'b0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!mid_evt && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached", mid_evt, 1);
    check("mid_data_driven", ps2_data_oe, 1);
    saved_done = done_cnt;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_clk_oe", ps2_clk_oe, 0);
    check("mid_rst_data_oe", ps2_data_oe, 0);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_done", done, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    kb_abort_after = 0;
    mid_evt = 1'b0;
    @(negedge clk);
    check("mid_no_done", done_cnt, saved_done);
    send(8'hF4, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("after_rst_f4");

    // Command held during a transfer: second byte waits for tx_ready.
    n = frames_seen;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_frame_q.push_back(exp_frame(8'h3C));
    exp_frame_q.push_back(exp_frame(8'h55));
    exp_status_q.push_back(2'b00);
    exp_status_q.push_back(2'b00);
    n_done_exp += 2;
    @(negedge clk);
    check("busy_accept", tx_ready, 0);
    tx_data = 8'h55;
    repeat (200) @(negedge clk);
    check("busy_ready_low", tx_ready, 0);
    check("busy_frames_mid", frames_seen - n, 0);
    wait_done("busy_first");
    @(negedge clk);
    check("busy_second_accept", tx_ready, 0);
    tx_valid = 1'b0;
    wait_done("busy_second");
    repeat (300) @(negedge clk);
    check("busy_two_frames", frames_seen - n, 2);

    check("done_count", done_cnt, n_done_exp);
    check("frame_q_empty", exp_frame_q.size(), 0);
    check("status_q_empty", exp_status_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
